// File: rtl/mips_fetch_unit.sv
// Instruction fetch for the single-cycle MIPS core: owns the PC, zero-latency imem fetch,
// next-PC select (jr > jump > branch > +4), stall holds everything, halts on break or bad target.
module mips_fetch_unit #(
    parameter int unsigned IMEM_AW  = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        imem_rd,
    input  logic               stall,
    input  logic               pcsrc,
    input  logic [31:0]        signimm,
    input  logic               jump,
    input  logic               jr,
    input  logic [31:0]        jr_addr,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        pc,
    output logic [31:0]        pcplus4,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic               halted,
    output logic               fault,
    output logic [31:0]        fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // One past the last byte address backed by instruction memory.
    localparam logic [32:0] MEM_LIMIT = 33'd4 << IMEM_AW;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] branch_tgt;
    logic [31:0] jump_tgt;
    logic [31:0] next_pc;
    logic        is_break;
    logic        tgt_fault;
    logic        run_go;

    assign imem_addr  = pc[IMEM_AW+1:2];
    assign pcplus4    = pc + 32'd4;
    assign branch_tgt = pcplus4 + {signimm[29:0], 2'b00};
    assign jump_tgt   = {pcplus4[31:28], imem_rd[25:0], 2'b00};

    always_comb begin
        next_pc = pcplus4;
        if (jr)
            next_pc = jr_addr;
        else if (jump)
            next_pc = jump_tgt;
        else if (pcsrc)
            next_pc = branch_tgt;
    end

    assign is_break  = (imem_rd[31:26] == 6'd0) && (imem_rd[5:0] == 6'h0D);
    // Running off the top of memory is caught here rather than letting imem_addr alias.
    assign tgt_fault = (next_pc[1:0] != 2'b00) || ({1'b0, next_pc} >= MEM_LIMIT);
    assign run_go    = (state == ST_RUN) && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_BOOT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (!stall && (is_break || tgt_fault))
                    state_nxt = ST_HALT;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            ST_RUN:  instr_valid = !stall;
            ST_HALT: halted      = 1'b1;
            default: ;
        endcase
    end

    assign instr = instr_valid ? imem_rd : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            fault       <= 1'b0;
            fetch_count <= 32'd0;
        end else if (run_go) begin
            fetch_count <= fetch_count + 32'd1;
            if (tgt_fault)
                fault <= 1'b1;
            if (!is_break && !tgt_fault)
                pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: small word memory model, hand-computed PC/flag expectations.
module tb_mips_fetch_unit;

    localparam int IMEM_AW = 6;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [31:0]        imem_rd;
    logic               stall = 1'b0;
    logic               pcsrc = 1'b0;
    logic [31:0]        signimm = 32'h0;
    logic               jump = 1'b0;
    logic               jr = 1'b0;
    logic [31:0]        jr_addr = 32'h0;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        pc;
    logic [31:0]        pcplus4;
    logic [31:0]        instr;
    logic               instr_valid;
    logic               halted;
    logic               fault;
    logic [31:0]        fetch_count;

    logic [31:0] mem [64];
    int tests = 0;
    int fails = 0;

    assign imem_rd = mem[imem_addr];

    always #5 clk = ~clk;

    mips_fetch_unit #(.IMEM_AW(IMEM_AW), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .imem_rd(imem_rd), .stall(stall),
        .pcsrc(pcsrc), .signimm(signimm), .jump(jump), .jr(jr), .jr_addr(jr_addr),
        .imem_addr(imem_addr), .pc(pc), .pcplus4(pcplus4), .instr(instr),
        .instr_valid(instr_valid), .halted(halted), .fault(fault),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse reset across one negedge; returns in BOOT, at a negedge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_ctrl();
        stall = 0; pcsrc = 0; jump = 0; jr = 0; signimm = 0; jr_addr = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[8] = 32'h0000_000D;

        #3;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_instr", instr, 32'h0);

        // 1: straight-line run into break at pc 32
        @(negedge clk);
        reset = 1'b0;
        chk("t1_boot_valid", {31'b0, instr_valid}, 32'd0);
        chk("t1_boot_pc", pc, 32'h0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("t1_pc%0d", i), pc, 32'(i * 4));
            chk($sformatf("t1_valid%0d", i), {31'b0, instr_valid}, 32'd1);
        end
        chk("t1_break_instr", instr, 32'h0000_000D);
        @(negedge clk);
        chk("t1_halted", {31'b0, halted}, 32'd1);
        chk("t1_halt_valid", {31'b0, instr_valid}, 32'd0);
        chk("t1_count", fetch_count, 32'd9);
        chk("t1_pc_hold", pc, 32'd32);
        chk("t1_fault", {31'b0, fault}, 32'd0);
        @(negedge clk);
        chk("t1_pc_hold2", pc, 32'd32);

        // 2: forward and backward branches
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t2_pc8", pc, 32'd8);
        pcsrc = 1; signimm = 32'd3;
        @(negedge clk);
        chk("t2_fwd", pc, 32'd24);
        signimm = 32'hFFFF_FFFA;
        @(negedge clk);
        chk("t2_back", pc, 32'd4);
        clear_ctrl();

        // 3: priority with all three asserted, then plain jump
        mem[16] = 32'h0800_0005;
        do_reset();
        @(negedge clk);
        jump = 1; jr = 1; pcsrc = 1; jr_addr = 32'h40; signimm = 32'd1;
        @(negedge clk);
        chk("t3_jr_prio", pc, 32'h40);
        chk("t3_instr", instr, 32'h0800_0005);
        jr = 0; pcsrc = 0;
        @(negedge clk);
        chk("t3_jump", pc, 32'h14);
        clear_ctrl();

        // 4: three stalled cycles at pc 12
        do_reset();
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("t4_pc12", pc, 32'd12);
        chk("t4_count0", fetch_count, 32'd3);
        stall = 1;
        #1;
        chk("t4_stall_valid", {31'b0, instr_valid}, 32'd0);
        chk("t4_stall_instr", instr, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("t4_hold_pc%0d", i), pc, 32'd12);
            chk($sformatf("t4_hold_cnt%0d", i), fetch_count, 32'd3);
        end
        @(negedge clk);
        chk("t4_hold_pc2", pc, 32'd12);
        stall = 0;
        #1;
        chk("t4_resume_valid", {31'b0, instr_valid}, 32'd1);
        @(negedge clk);
        chk("t4_resume_pc", pc, 32'd16);
        chk("t4_resume_cnt", fetch_count, 32'd4);

        // 5: misaligned jr, out-of-range jr, and falling off the top
        do_reset();
        @(negedge clk);
        jr = 1; jr_addr = 32'h22;
        @(negedge clk);
        jr = 0;
        chk("t5a_fault", {31'b0, fault}, 32'd1);
        chk("t5a_halted", {31'b0, halted}, 32'd1);
        chk("t5a_pc", pc, 32'h0);
        chk("t5a_count", fetch_count, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t5a_sticky", {31'b0, fault}, 32'd1);
        do_reset();
        chk("t5_rst_clears", {31'b0, fault}, 32'd0);
        @(negedge clk);
        jr = 1; jr_addr = 32'h100;
        @(negedge clk);
        jr = 0;
        chk("t5b_fault", {31'b0, fault}, 32'd1);
        chk("t5b_halted", {31'b0, halted}, 32'd1);
        chk("t5b_pc", pc, 32'h0);
        do_reset();
        @(negedge clk);
        jr = 1; jr_addr = 32'hFC;
        @(negedge clk);
        jr = 0;
        chk("t5c_top", pc, 32'hFC);
        chk("t5c_nofault", {31'b0, fault}, 32'd0);
        @(negedge clk);
        chk("t5c_wrap_fault", {31'b0, fault}, 32'd1);
        chk("t5c_wrap_pc", pc, 32'hFC);

        // break and fault in the same cycle
        mem[0] = 32'h0000_000D;
        do_reset();
        @(negedge clk);
        jr = 1; jr_addr = 32'h22;
        @(negedge clk);
        jr = 0;
        chk("tbf_halted", {31'b0, halted}, 32'd1);
        chk("tbf_fault", {31'b0, fault}, 32'd1);
        mem[0] = 32'h0;

        // 6: async reset mid-cycle while running at pc 20
        do_reset();
        for (int i = 0; i < 6; i++) @(negedge clk);
        chk("t6_pc20", pc, 32'd20);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_pc", pc, 32'h0);
        chk("t6_async_valid", {31'b0, instr_valid}, 32'd0);
        chk("t6_async_cnt", fetch_count, 32'd0);
        chk("t6_async_instr", instr, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("t6_boot_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        chk("t6_run_valid", {31'b0, instr_valid}, 32'd1);
        chk("t6_run_pc", pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle MIPS core. It sits directly upstream of the instruction memory.
- Owns the program counter, drives the word address into the instruction memory, and receives the instruction word back.
- Selects the next PC from sequential, branch, jump and jump-register sources.
- Provides stall, halt-on-`break` and fault detection through a small control FSM.

Parameters:
- IMEM_AW, 6, instruction-memory word-address width; imem_addr = pc[IMEM_AW+1:2].
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_rd  input  32  instruction word returned combinationally by instruction memory.
- stall  input  1  hold PC and FSM state this cycle.
- pcsrc  input  1  branch taken (from decode/ALU zero logic).
- signimm  input  32  sign-extended branch immediate.
- jump  input  1  J/JAL taken.
- jr  input  1  JR taken.
- jr_addr  input  32  register value for JR target.
- imem_addr  output  IMEM_AW  word address to instruction memory.
- pc  output  32  current PC.
- pcplus4  output  32  pc + 4.
- instr  output  32  fetched instruction; 32'h0 when instr_valid = 0.
- instr_valid  output  1  instr is a real instruction to execute this cycle.
- halted  output  1  FSM in HALT.
- fault  output  1  sticky; set on out-of-range or misaligned fetch target.
- fetch_count  output  32  number of cycles with instr_valid = 1; wraps at 2^32.

Behaviour:
- Reset (async, any time including mid-operation):
  - pc = RESET_PC, state = BOOT, fault = 0, fetch_count = 0.
  - Outputs: instr_valid = 0, halted = 0, instr = 0.
- imem_addr = pc[IMEM_AW+1:2]; purely combinational from the pc register. Zero-latency fetch: imem_rd for pc is valid in the same cycle.
- Arithmetic (all 32-bit, overflow wraps):
  - pcplus4 = pc + 4.
  - Branch target = pcplus4 + (signimm << 2).
  - Jump target = {pcplus4[31:28], imem_rd[25:0], 2'b00}.
- Next-PC priority (RUN only): jr > jump > pcsrc > pcplus4. Simultaneous requests resolve by this priority, with no error.
- FSM states: BOOT, RUN, HALT.
  - BOOT: lasts exactly one cycle after reset deassert; instr_valid = 0; PC held. Next state is RUN; stall is ignored in BOOT.
  - RUN: instr_valid = ~stall.
  - RUN with stall = 1: pc, fetch_count and state held; control inputs ignored.
  - RUN without stall: pc <= selected next PC; fetch_count += 1.
- Halt detection: in RUN, a fetched instruction with imem_rd[31:26] = 0 and imem_rd[5:0] = 6'h0D (`break`):
  - is reported valid that cycle and counted;
  - PC is not advanced;
  - state moves to HALT.
- HALT: PC frozen, instr_valid = 0, halted = 1. Only reset exits HALT.
- Fault checking on the selected next PC in RUN (not stalled):
  - Fault conditions: next PC bits [1:0] != 0, or next PC >= 4 * 2^IMEM_AW.
  - On fault: fault <= 1, PC not updated, state <= HALT.
  - The faulting cycle's instruction is still counted as valid.
  - A `break` and a fault in the same cycle: both halted and fault are set.
- PC wrap past the top of memory is treated as a fault, never a silent wrap of imem_addr.
- instr = instr_valid ? imem_rd : 32'h0.

Test Plan:
1. Reset release, no control inputs, memory holds 8 NOPs then `break` (32'h0000_000D):
   - cycle 1 is BOOT, with instr_valid = 0;
   - pc steps 0, 4, ..., 32;
   - HALT is entered after the `break` at pc = 32;
   - fetch_count = 9, halted = 1, and pc stays at 32.
2. At pc = 8, pcsrc = 1 with signimm = 3 -> pc = 24 next cycle. At pc = 24, pcsrc = 1 with signimm = 32'hFFFF_FFFA -> pc = 4.
3. jump, jr and pcsrc all asserted together, jr_addr = 32'h40 -> pc = 32'h40. Then jump alone with imem_rd[25:0] = 26'h5 -> pc = 32'h14.
4. stall held high for 3 cycles at pc = 12:
   - pc stays at 12, instr_valid = 0 and instr = 0;
   - fetch_count is unchanged;
   - the step to 16 resumes on the first unstalled cycle.
5. jr = 1 with jr_addr = 32'h22 (misaligned), then a separate run with jr_addr = 32'h100 when IMEM_AW = 6 (out of range):
   - each case sets fault = 1 and halted = 1, with pc unchanged;
   - fault stays sticky until reset.
6. Assert reset asynchronously, mid-cycle, while in RUN at pc = 20 -> pc = 0, outputs cleared immediately with no clock edge, and BOOT is re-entered on release.
